// File: rtl/wbox_reg_file.sv
// Wbox integer register file: commits Mbox writebacks and serves two bypassed read ports.
// A busy scoreboard of in-flight destinations raises a hazard to hold decode issue.
module wbox_reg_file #(
  parameter int unsigned WIDTH    = 64,
  parameter int unsigned NREGS    = 32,
  parameter int unsigned ZERO_REG = 31,
  localparam int unsigned AW      = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [AW-1:0]    ra_addr,
  input  logic [AW-1:0]    rb_addr,
  output logic [WIDTH-1:0] ra_data,
  output logic [WIDTH-1:0] rb_data,
  input  logic [AW-1:0]    w_addr,
  input  logic [WIDTH-1:0] w_data,
  input  logic             w_en,
  input  logic             stall_in,
  input  logic             issue_valid,
  input  logic [AW-1:0]    issue_dest,
  input  logic             issue_dest_valid,
  output logic             hazard,
  output logic [NREGS-1:0] busy
);

  localparam logic [AW-1:0] ZR = AW'(ZERO_REG);

  logic [WIDTH-1:0] regs_q [NREGS];
  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_d;
  logic             wr_fire;
  logic             set_fire;
  logic             src_a_busy;
  logic             src_b_busy;
  logic             dst_busy;

  assign wr_fire = w_en && (w_addr != ZR);

  // Read port A: zero register first, then same-cycle writeback bypass, then storage.
  always_comb begin
    ra_data = regs_q[ra_addr];
    if (ra_addr == ZR) begin
      ra_data = '0;
    end else if (w_en && (w_addr == ra_addr)) begin
      ra_data = w_data;
    end
  end

  // Read port B: same priority as port A.
  always_comb begin
    rb_data = regs_q[rb_addr];
    if (rb_addr == ZR) begin
      rb_data = '0;
    end else if (w_en && (w_addr == rb_addr)) begin
      rb_data = w_data;
    end
  end

  // A busy register being written back this cycle no longer blocks: sources take the bypass.
  always_comb begin
    src_a_busy = busy_q[ra_addr] && !(w_en && (w_addr == ra_addr));
    src_b_busy = busy_q[rb_addr] && !(w_en && (w_addr == rb_addr));
    dst_busy   = issue_dest_valid && busy_q[issue_dest] &&
                 !(w_en && (w_addr == issue_dest));
    hazard     = issue_valid && (src_a_busy || src_b_busy || dst_busy);
  end

  assign set_fire = issue_valid && !hazard && !stall_in && issue_dest_valid &&
                    (issue_dest != ZR);

  // Set is applied after clear so a fresh producer on the retiring register stays outstanding.
  always_comb begin
    busy_d = busy_q;
    if (wr_fire) begin
      busy_d[w_addr] = 1'b0;
    end
    if (set_fire) begin
      busy_d[issue_dest] = 1'b1;
    end
    busy_d[ZERO_REG] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q <= '0;
      for (int unsigned i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      busy_q <= busy_d;
      if (wr_fire) begin
        regs_q[w_addr] <= w_data;
      end
    end
  end

  assign busy = busy_q;

endmodule
